// File: rtl/flappy_pkg.sv
// Shared constants, state encoding and LFSR step function for the flappy game blocks.
package flappy_pkg;

  localparam int COORD_W  = 10;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_e;

  // 16-bit Fibonacci step, taps 16,14,13,11 (bit indices 15,13,12,10).
  function automatic logic [15:0] lfsr16_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/obstacle_gen_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes its low OUT_W bits.
module lfsr16
  import flappy_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          OUT_W = 16
) (
  input  logic             Clk,
  input  logic             reset,
  output logic [OUT_W-1:0] lfsr_o
);

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  assign lfsr_d = lfsr16_next(lfsr_q);

  always_ff @(posedge Clk) begin
    if (reset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/obstacle_gen.sv
// Scrolling pipe obstacle generator with score counter and INIT/RUN/HALT control.
// Optional speed-up on every eighth passed obstacle: define OBSTACLE_SPEEDUP_EN.
module obstacle_gen
  import flappy_pkg::*;
#(
  parameter int          X_START   = SCREEN_W,
  parameter int          Y_MIN     = 120,
  parameter int          Y_INIT    = 240,
  parameter int          STEP_DIV  = 250000,
  parameter int          SPEED     = 2,
  parameter int          SPEED_MAX = 6,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               Clk,
  input  logic               reset,
  input  logic               Start,
  input  logic               Ack,
  input  logic               Lose,
  output logic [COORD_W-1:0] X_Edge,
  output logic [COORD_W-1:0] Y_Edge,
  output logic [7:0]         Score,
  output logic               Pass,
  output logic               Q_Init,
  output logic               Q_Run,
  output logic               Q_Halt
);

  localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(STEP_DIV - 1);
  localparam logic [COORD_W-1:0] X_START_C = COORD_W'(X_START);
  localparam logic [COORD_W-1:0] Y_MIN_C   = COORD_W'(Y_MIN);
  localparam logic [COORD_W-1:0] Y_INIT_C  = COORD_W'(Y_INIT);
  // Base speed is never allowed above the ceiling.
  localparam logic [COORD_W-1:0] SPEED_C   = COORD_W'((SPEED > SPEED_MAX) ? SPEED_MAX : SPEED);

  state_e             state_q;
  logic               q_init_q, q_run_q, q_halt_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [COORD_W-1:0] x_q, y_q;
  logic [7:0]         score_q;
  logic               pass_q;

  logic [6:0]         lfsr_low;
  logic [COORD_W-1:0] speed;
  logic               tick_d;
  logic [COORD_W-1:0] x_dec_d;
  logic [COORD_W-1:0] y_spawn_d;
  logic [7:0]         score_d;

  lfsr16 #(
    .SEED  (LFSR_SEED),
    .OUT_W (7)
  ) u_lfsr (
    .Clk    (Clk),
    .reset  (reset),
    .lfsr_o (lfsr_low)
  );

`ifdef OBSTACLE_SPEEDUP_EN
  localparam logic [COORD_W-1:0] SPEED_MAX_C = COORD_W'(SPEED_MAX);
  logic [COORD_W-1:0] speed_q;

  always_ff @(posedge Clk) begin
    if (reset) begin
      speed_q <= SPEED_C;
    end else if (state_q == ST_INIT && Start) begin
      speed_q <= SPEED_C;
    end else if (state_q == ST_RUN && !Lose && tick_d && !(x_q > speed_q)
                 && score_d[2:0] == 3'd0 && speed_q < SPEED_MAX_C) begin
      speed_q <= speed_q + COORD_W'(1);
    end
  end

  assign speed = speed_q;
`else
  assign speed = SPEED_C;
`endif

  assign tick_d    = (cnt_q == CNT_LAST);
  assign x_dec_d   = x_q - speed;
  assign y_spawn_d = Y_MIN_C + {{(COORD_W-7){1'b0}}, lfsr_low};
  assign score_d   = (score_q == 8'hFF) ? 8'hFF : score_q + 8'd1;

  always_ff @(posedge Clk) begin
    pass_q <= 1'b0;
    if (reset) begin
      state_q  <= ST_INIT;
      q_init_q <= 1'b1;
      q_run_q  <= 1'b0;
      q_halt_q <= 1'b0;
      cnt_q    <= '0;
      x_q      <= X_START_C;
      y_q      <= Y_INIT_C;
      score_q  <= 8'd0;
    end else begin
      case (state_q)
        ST_INIT: begin
          x_q <= X_START_C;
          y_q <= Y_INIT_C;
          if (Start) begin
            state_q  <= ST_RUN;
            q_init_q <= 1'b0;
            q_run_q  <= 1'b1;
            score_q  <= 8'd0;
            cnt_q    <= '0;
          end
        end
        ST_RUN: begin
          // A collision freezes the pipe even if a scroll step lands on the same edge.
          if (Lose) begin
            state_q  <= ST_HALT;
            q_run_q  <= 1'b0;
            q_halt_q <= 1'b1;
          end else if (tick_d) begin
            cnt_q <= '0;
            if (x_q > speed) begin
              x_q <= x_dec_d;
            end else begin
              x_q     <= X_START_C;
              y_q     <= y_spawn_d;
              score_q <= score_d;
              pass_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HALT: begin
          if (Ack) begin
            state_q  <= ST_INIT;
            q_halt_q <= 1'b0;
            q_init_q <= 1'b1;
            x_q      <= X_START_C;
            y_q      <= Y_INIT_C;
          end
        end
        default: begin
          state_q  <= ST_INIT;
          q_init_q <= 1'b1;
          q_run_q  <= 1'b0;
          q_halt_q <= 1'b0;
        end
      endcase
    end
  end

  assign X_Edge = x_q;
  assign Y_Edge = y_q;
  assign Score  = score_q;
  assign Pass   = pass_q;
  assign Q_Init = q_init_q;
  assign Q_Run  = q_run_q;
  assign Q_Halt = q_halt_q;

endmodule

// File: tb/tb_obstacle_gen.sv
// Self-checking bench for obstacle_gen (STEP_DIV=4, SPEED=2), with a respawn scoreboard.
module tb_obstacle_gen;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       Start = 1'b0;
  logic       Ack = 1'b0;
  logic       Lose = 1'b0;
  logic [9:0] X_Edge, Y_Edge;
  logic [7:0] Score;
  logic       Pass, Q_Init, Q_Run, Q_Halt;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_score_q[$];

  logic [15:0] lfsr_m, lfsr_prev;

  obstacle_gen #(
    .STEP_DIV (4),
    .SPEED    (2)
  ) dut (
    .Clk    (Clk),
    .reset  (reset),
    .Start  (Start),
    .Ack    (Ack),
    .Lose   (Lose),
    .X_Edge (X_Edge),
    .Y_Edge (Y_Edge),
    .Score  (Score),
    .Pass   (Pass),
    .Q_Init (Q_Init),
    .Q_Run  (Q_Run),
    .Q_Halt (Q_Halt)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  // Reference LFSR; lfsr_prev is the value the DUT held before the latest edge.
  always @(posedge Clk) begin
    lfsr_prev <= lfsr_m;
    lfsr_m    <= reset ? 16'hACE1 : lfsr_step(lfsr_m);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    n_tests++; if (Q_Init !== 1'b1) begin n_fail++; $display("FAIL reset_q_init got %0b want 1", Q_Init); end
    n_tests++; if (Q_Run !== 1'b0 || Q_Halt !== 1'b0) begin n_fail++; $display("FAIL reset_q_other got run=%0b halt=%0b want 0,0", Q_Run, Q_Halt); end
    n_tests++; if (X_Edge !== 10'd640) begin n_fail++; $display("FAIL reset_x got %0d want 640", X_Edge); end
    n_tests++; if (Y_Edge !== 10'd240) begin n_fail++; $display("FAIL reset_y got %0d want 240", Y_Edge); end
    n_tests++; if (Score !== 8'd0) begin n_fail++; $display("FAIL reset_score got %0d want 0", Score); end
    n_tests++; if (Pass !== 1'b0) begin n_fail++; $display("FAIL reset_pass got %0b want 0", Pass); end
    $display("[TB] reset: X=%0d Y=%0d Score=%0d", X_Edge, Y_Edge, Score);
  endtask

  task automatic test_start;
    Start = 1'b1;
    exp_score_q.push_back(1);
    step(1);
    Start = 1'b0;
    n_tests++; if (Q_Run !== 1'b1 || Q_Init !== 1'b0) begin n_fail++; $display("FAIL start_state got run=%0b init=%0b want 1,0", Q_Run, Q_Init); end
    n_tests++; if (Score !== 8'd0) begin n_fail++; $display("FAIL start_score got %0d want 0", Score); end
    step(3);
    n_tests++; if (X_Edge !== 10'd640) begin n_fail++; $display("FAIL start_x_pre_tick got %0d want 640", X_Edge); end
    step(1);
    n_tests++; if (X_Edge !== 10'd638) begin n_fail++; $display("FAIL start_x_tick1 got %0d want 638", X_Edge); end
    step(4);
    n_tests++; if (X_Edge !== 10'd636) begin n_fail++; $display("FAIL start_x_tick2 got %0d want 636", X_Edge); end
    $display("[TB] start: X after two ticks=%0d", X_Edge);
  endtask

  task automatic test_respawn;
    int   last_x;
    bit   seen;
    int   exp_s;
    logic [9:0] exp_y;
    last_x = X_Edge;
    seen   = 1'b0;
    for (int c = 0; c < 2000 && !seen; c++) begin
      step(1);
      if (Pass === 1'b1) begin
        seen  = 1'b1;
        exp_y = 10'd120 + {3'b000, lfsr_prev[6:0]};
        if (exp_score_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL respawn_unexpected got Pass=1 want no pending respawn");
        end else begin
          exp_s = exp_score_q.pop_front();
          n_tests++; if (Score !== 8'(exp_s)) begin n_fail++; $display("FAIL respawn_score got %0d want %0d", Score, exp_s); end
        end
        n_tests++; if (X_Edge !== 10'd640) begin n_fail++; $display("FAIL respawn_x got %0d want 640", X_Edge); end
        n_tests++; if (last_x != 2) begin n_fail++; $display("FAIL respawn_last_x got %0d want 2", last_x); end
        n_tests++; if (Y_Edge !== exp_y) begin n_fail++; $display("FAIL respawn_y got %0d want %0d", Y_Edge, exp_y); end
        n_tests++; if (Y_Edge < 10'd120 || Y_Edge > 10'd247) begin n_fail++; $display("FAIL respawn_y_range got %0d want 120..247", Y_Edge); end
        $display("[TB] respawn: X=%0d Y=%0d Score=%0d", X_Edge, Y_Edge, Score);
      end else begin
        last_x = X_Edge;
      end
    end
    if (!seen) begin
      n_tests++; n_fail++;
      $display("FAIL respawn_timeout got no Pass want Pass within 2000 cycles");
    end
    step(1);
    n_tests++; if (Pass !== 1'b0) begin n_fail++; $display("FAIL pass_width got %0b want 0", Pass); end
  endtask

  // Entered one edge after a respawn tick; the next tick is three edges away.
  task automatic test_lose_on_tick;
    step(2);
    Lose = 1'b1;
    step(1);
    Lose = 1'b0;
    n_tests++; if (Q_Halt !== 1'b1 || Q_Run !== 1'b0) begin n_fail++; $display("FAIL lose_state got halt=%0b run=%0b want 1,0", Q_Halt, Q_Run); end
    n_tests++; if (X_Edge !== 10'd640) begin n_fail++; $display("FAIL lose_x got %0d want 640", X_Edge); end
    n_tests++; if (Pass !== 1'b0) begin n_fail++; $display("FAIL lose_pass got %0b want 0", Pass); end
    step(8);
    n_tests++; if (X_Edge !== 10'd640 || Score !== 8'd1) begin n_fail++; $display("FAIL halt_frozen got X=%0d Score=%0d want 640,1", X_Edge, Score); end
    $display("[TB] lose on tick: halt=%0b X=%0d", Q_Halt, X_Edge);
  endtask

  task automatic test_halt_ack;
    Start = 1'b1;
    step(2);
    Start = 1'b0;
    n_tests++; if (Q_Halt !== 1'b1) begin n_fail++; $display("FAIL halt_start_ignored got halt=%0b want 1", Q_Halt); end
    Ack = 1'b1;
    step(1);
    Ack = 1'b0;
    n_tests++; if (Q_Init !== 1'b1 || Q_Halt !== 1'b0) begin n_fail++; $display("FAIL ack_state got init=%0b halt=%0b want 1,0", Q_Init, Q_Halt); end
    n_tests++; if (X_Edge !== 10'd640 || Y_Edge !== 10'd240) begin n_fail++; $display("FAIL ack_reload got X=%0d Y=%0d want 640,240", X_Edge, Y_Edge); end
    n_tests++; if (Score !== 8'd1) begin n_fail++; $display("FAIL ack_score_kept got %0d want 1", Score); end
    Lose = 1'b1;
    step(2);
    Lose = 1'b0;
    n_tests++; if (Q_Init !== 1'b1) begin n_fail++; $display("FAIL init_lose_ignored got init=%0b want 1", Q_Init); end
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    n_tests++; if (Score !== 8'd0 || Q_Run !== 1'b1) begin n_fail++; $display("FAIL restart got Score=%0d run=%0b want 0,1", Score, Q_Run); end
    $display("[TB] ack/restart: run=%0b Score=%0d", Q_Run, Score);
  endtask

  task automatic test_reset_midgame;
    step(5);
    n_tests++; if (X_Edge !== 10'd638) begin n_fail++; $display("FAIL midgame_x got %0d want 638", X_Edge); end
    reset = 1'b1;
    Start = 1'b1;
    Lose  = 1'b1;
    step(1);
    reset = 1'b0;
    Start = 1'b0;
    Lose  = 1'b0;
    n_tests++; if (Q_Init !== 1'b1 || Q_Run !== 1'b0 || Q_Halt !== 1'b0) begin n_fail++; $display("FAIL midreset_state got %0b%0b%0b want 100", Q_Init, Q_Run, Q_Halt); end
    n_tests++; if (X_Edge !== 10'd640 || Score !== 8'd0) begin n_fail++; $display("FAIL midreset_vals got X=%0d Score=%0d want 640,0", X_Edge, Score); end
    $display("[TB] mid-game reset: init=%0b X=%0d", Q_Init, X_Edge);
  endtask

  // Checks the first scroll step after every respawn against the expected speed.
  task automatic test_speed;
    int n_resp;
    int target;
    int prev_x;
    int exp_step;
    bit check_next;
`ifdef OBSTACLE_SPEEDUP_EN
    target = 40;
`else
    target = 10;
`endif
    Start = 1'b1;
    step(1);
    Start = 1'b0;
    n_resp     = 0;
    check_next = 1'b1;
    prev_x     = X_Edge;
    for (int c = 0; c < 80000 && n_resp < target; c++) begin
      step(1);
      if (Pass === 1'b1) begin
        n_resp++;
        check_next = 1'b1;
        n_tests++; if (Score !== 8'(n_resp)) begin n_fail++; $display("FAIL speed_score got %0d want %0d", Score, n_resp); end
      end else if (X_Edge != 10'(prev_x) && check_next) begin
        check_next = 1'b0;
`ifdef OBSTACLE_SPEEDUP_EN
        exp_step = (2 + n_resp / 8 > 6) ? 6 : 2 + n_resp / 8;
`else
        exp_step = 2;
`endif
        n_tests++;
        if (prev_x - int'(X_Edge) != exp_step) begin
          n_fail++;
          $display("FAIL speed_step after %0d respawns got %0d want %0d", n_resp, prev_x - int'(X_Edge), exp_step);
        end
        $display("[TB] speed: respawns=%0d step=%0d", n_resp, prev_x - int'(X_Edge));
      end
      prev_x = X_Edge;
    end
    if (n_resp < target) begin
      n_tests++; n_fail++;
      $display("FAIL speed_timeout got %0d respawns want %0d", n_resp, target);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_start();
    test_respawn();
    test_lose_on_tick();
    test_halt_ack();
    test_reset_midgame();
    test_speed();
    chk("final_pending_respawns", exp_score_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
